// File: rtl/mac_cyv_fix2half_out_if.sv
// Stream bundle for the fixed-to-half converter: fixed-point operands in, binary16 results out.
// The master modport is the side that feeds operands and consumes results.
interface mac_cyv_fix2half_out_if #(
  parameter int FIXEDSIZE = 32,
  parameter int FLOATSIZE = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [FIXEDSIZE-1:0] in_fixed;
  logic                 out_valid;
  logic                 out_ready;
  logic [FLOATSIZE-1:0] out_float;
  logic                 out_overflow;
  logic                 out_underflow;

  modport master (
    output in_valid, in_fixed, out_ready,
    input  in_ready, out_valid, out_float, out_overflow, out_underflow
  );

  modport slave (
    input  in_valid, in_fixed, out_ready,
    output in_ready, out_valid, out_float, out_overflow, out_underflow
  );
endinterface

// File: rtl/mac_cyv_fix2half_out.sv
// Signed fixed-point accumulator result to IEEE-754 binary16, round-to-nearest-even.
// Three-stage elastic pipeline: sign/magnitude, normalise, pack+round.
module mac_cyv_fix2half_out #(
  parameter int FIXEDSIZE  = 32,
  parameter int RADIXPOINT = 20,
  parameter int EXPBITS    = 5,
  parameter int MANBITS    = 10,
  parameter int FLOATSIZE  = 1 + EXPBITS + MANBITS
) (
  input  logic                  clk,
  input  logic                  areset,
  mac_cyv_fix2half_out_if.slave bus
);
  localparam int BIAS = 2 ** (EXPBITS - 1) - 1;
  localparam int EMAX = 2 ** EXPBITS - 1;
  localparam int PW   = $clog2(FIXEDSIZE);
  localparam int EW   = 16;

  // stage 1: sign and magnitude
  logic                 v1_q, s1_q;
  logic [FIXEDSIZE-1:0] mag1_q, mag1_d;
  // stage 2: leading-one position and left-justified magnitude
  logic                 v2_q, s2_q, z2_q;
  logic [PW-1:0]        p2_q, p1_d;
  logic [FIXEDSIZE-1:0] norm2_q, norm1_d;
  // stage 3: packed result
  logic                 v3_q, ovf3_q, unf3_q;
  logic [FLOATSIZE-1:0] float3_q, float_d;
  logic                 ovf_d, unf_d;

  logic load1, load2, load3;

  assign load3        = !v3_q || bus.out_ready;
  assign load2        = !v2_q || load3;
  assign load1        = !v1_q || load2;
  assign bus.in_ready = load1 && !areset;

  assign bus.out_valid     = v3_q;
  assign bus.out_float     = float3_q;
  assign bus.out_overflow  = ovf3_q;
  assign bus.out_underflow = unf3_q;

  // Negating the most negative value wraps back to 2^(N-1), which is the correct unsigned magnitude.
  assign mag1_d = bus.in_fixed[FIXEDSIZE-1] ? (~bus.in_fixed + FIXEDSIZE'(1)) : bus.in_fixed;

  always_comb begin
    p1_d = '0;
    for (int i = 0; i < FIXEDSIZE; i++) begin
      if (mag1_q[i]) p1_d = PW'(i);
    end
  end

  assign norm1_d = mag1_q << (PW'(FIXEDSIZE - 1) - p1_d);

  logic signed [EW-1:0]   e_d, sh_s, exp_r;
  logic                   subn;
  logic [EW-1:0]          sh_amt;
  logic [FIXEDSIZE-1:0]   shifted;
  logic                   lost, guard, sticky, inc;
  logic [MANBITS:0]       sig;
  logic [MANBITS+1:0]     rnd;

  always_comb begin
    e_d    = $signed({{(EW-PW){1'b0}}, p2_q}) - EW'(RADIXPOINT) + EW'(BIAS);
    subn   = (e_d <= 0);
    sh_s   = '0;
    if (subn) begin
      sh_s = EW'(1) - e_d;
      if (sh_s > EW'(FIXEDSIZE)) sh_s = EW'(FIXEDSIZE);
    end
    sh_amt  = $unsigned(sh_s);
    shifted = norm2_q >> sh_amt;
    lost    = ((shifted << sh_amt) != norm2_q);
    // sig keeps the hidden-bit position so a subnormal that rounds up lands on the min normal
    sig     = shifted[FIXEDSIZE-1 -: MANBITS+1];
    guard   = shifted[FIXEDSIZE-2-MANBITS];
    sticky  = (|shifted[FIXEDSIZE-3-MANBITS:0]) | lost;
    inc     = guard & (sticky | sig[0]);
    rnd     = {1'b0, sig} + (MANBITS+2)'(inc);
    if (subn) exp_r = $signed({{(EW-1){1'b0}}, rnd[MANBITS]});
    else      exp_r = e_d + $signed({{(EW-1){1'b0}}, rnd[MANBITS+1]});

    float_d = {s2_q, exp_r[EXPBITS-1:0], rnd[MANBITS-1:0]};
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (z2_q) begin
      float_d = '0;
    end else if (exp_r >= EW'(EMAX)) begin
      float_d = {s2_q, {EXPBITS{1'b1}}, {MANBITS{1'b0}}};
      ovf_d   = 1'b1;
    end else if (exp_r == '0) begin
      unf_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      float3_q <= '0;
      ovf3_q   <= 1'b0;
      unf3_q   <= 1'b0;
    end else begin
      if (load1) begin
        v1_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_q   <= bus.in_fixed[FIXEDSIZE-1];
          mag1_q <= mag1_d;
        end
      end
      if (load2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          s2_q    <= s1_q;
          z2_q    <= (mag1_q == '0);
          p2_q    <= p1_d;
          norm2_q <= norm1_d;
        end
      end
      // stage 3 only changes when the consumer takes the result or it is empty
      if (load3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          float3_q <= float_d;
          ovf3_q   <= ovf_d;
          unf3_q   <= unf_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_cyv_fix2half_out.sv
// Directed bench for the fixed-to-half converter; one DUT at Q.20, one at integer scaling.
module tb_mac_cyv_fix2half_out;
  logic clk = 1'b0;
  logic areset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mac_cyv_fix2half_out_if busa ();
  mac_cyv_fix2half_out_if busb ();

  mac_cyv_fix2half_out #(.RADIXPOINT(20)) dut_a (.clk(clk), .areset(areset), .bus(busa.slave));
  mac_cyv_fix2half_out #(.RADIXPOINT(0))  dut_b (.clk(clk), .areset(areset), .bus(busb.slave));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] x;
    logic [15:0] f;
    logic        o;
    logic        u;
  } vec_t;

  vec_t va [13] = '{
    '{32'h0010_0000, 16'h3C00, 1'b0, 1'b0},
    '{32'hFFD8_0000, 16'hC100, 1'b0, 1'b0},
    '{32'h0010_0200, 16'h3C00, 1'b0, 1'b0},
    '{32'h0010_0600, 16'h3C02, 1'b0, 1'b0},
    '{32'h0010_0201, 16'h3C01, 1'b0, 1'b0},
    '{32'h0010_01FF, 16'h3C00, 1'b0, 1'b0},
    '{32'h0000_0001, 16'h0010, 1'b0, 1'b1},
    '{32'hFFFF_FFFF, 16'h8010, 1'b0, 1'b1},
    '{32'h0000_0000, 16'h0000, 1'b0, 1'b0},
    '{32'h8000_0000, 16'hE800, 1'b0, 1'b0},
    '{32'h7FFF_FFFF, 16'h6800, 1'b0, 1'b0},
    '{32'h0000_0040, 16'h0400, 1'b0, 1'b0},
    '{32'h0000_003F, 16'h03F0, 1'b0, 1'b1}
  };

  vec_t vb [6] = '{
    '{32'h0001_0000, 16'h7C00, 1'b1, 1'b0},
    '{32'h0000_FFE0, 16'h7BFF, 1'b0, 1'b0},
    '{32'h0000_FFEF, 16'h7BFF, 1'b0, 1'b0},
    '{32'h0000_FFF0, 16'h7C00, 1'b1, 1'b0},
    '{32'hFFFF_0000, 16'hFC00, 1'b1, 1'b0},
    '{32'h0000_0001, 16'h3C00, 1'b0, 1'b0}
  };

  // Drives one operand into an idle pipe and returns what comes out plus the edge count.
  task automatic run_one(input bit sel_b, input logic [31:0] x, output logic [15:0] f,
                         output logic o, output logic u, output int lat);
    if (sel_b) begin busb.in_valid = 1'b1; busb.in_fixed = x; end
    else       begin busa.in_valid = 1'b1; busa.in_fixed = x; end
    @(posedge clk); #1;
    busa.in_valid = 1'b0;
    busb.in_valid = 1'b0;
    lat = 1;
    while (!(sel_b ? busb.out_valid : busa.out_valid) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    f = sel_b ? busb.out_float     : busa.out_float;
    o = sel_b ? busb.out_overflow  : busa.out_overflow;
    u = sel_b ? busb.out_underflow : busa.out_underflow;
    $display("txn dut=%s in=%h out=%h ovf=%0b unf=%0b lat=%0d", sel_b ? "b" : "a", x, f, o, u, lat);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    busa.in_valid = 1'b0; busa.in_fixed = '0; busa.out_ready = 1'b1;
    busb.in_valid = 1'b0; busb.in_fixed = '0; busb.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busa.out_valid !== 1'b0 || busb.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b/%b expected 0/0", busa.out_valid, busb.out_valid);
    end
    checks++;
    if (busa.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0", busa.in_ready);
    end
    checks++;
    if (busa.out_float !== 16'h0000 || busa.out_overflow !== 1'b0 || busa.out_underflow !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got %h %b %b expected 0000 0 0",
                         busa.out_float, busa.out_overflow, busa.out_underflow);
    end
    areset = 1'b0;
    #1;
    checks++;
    if (busa.in_ready !== 1'b1) begin
      errors++; $display("FAIL release_in_ready: got %b expected 1", busa.in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    logic [15:0] f; logic o, u; int lat;
    run_one(1'b0, 32'h0010_0000, f, o, u, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL latency: got %0d expected 3", lat); end
    checks++;
    if (f !== 16'h3C00 || o !== 1'b0 || u !== 1'b0) begin
      errors++; $display("FAIL latency_value: got %h %b %b expected 3c00 0 0", f, o, u);
    end
    checks++;
    if (busa.out_valid !== 1'b0) begin
      errors++; $display("FAIL latency_drain: out_valid got %b expected 0", busa.out_valid);
    end
  endtask

  task automatic test_vectors();
    logic [15:0] f; logic o, u; int lat;
    for (int i = 0; i < 13; i++) begin
      run_one(1'b0, va[i].x, f, o, u, lat);
      checks++;
      if (f !== va[i].f) begin errors++; $display("FAIL vec_a%0d_float: got %h expected %h", i, f, va[i].f); end
      checks++;
      if (o !== va[i].o || u !== va[i].u) begin
        errors++; $display("FAIL vec_a%0d_flags: got ovf=%b unf=%b expected ovf=%b unf=%b", i, o, u, va[i].o, va[i].u);
      end
    end
  endtask

  task automatic test_radix0();
    logic [15:0] f; logic o, u; int lat;
    for (int i = 0; i < 6; i++) begin
      run_one(1'b1, vb[i].x, f, o, u, lat);
      checks++;
      if (f !== vb[i].f) begin errors++; $display("FAIL vec_b%0d_float: got %h expected %h", i, f, vb[i].f); end
      checks++;
      if (o !== vb[i].o || u !== vb[i].u) begin
        errors++; $display("FAIL vec_b%0d_flags: got ovf=%b unf=%b expected ovf=%b unf=%b", i, o, u, vb[i].o, vb[i].u);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, cyc = 0;
    busa.out_ready = 1'b1;
    while (got < 8 && cyc < 40) begin
      busa.in_valid = (sent < 8);
      busa.in_fixed = va[sent < 8 ? sent : 7].x;
      #1;
      if (busa.out_valid) begin
        $display("txn b2b idx=%0d out=%h cyc=%0d", got, busa.out_float, cyc);
        checks++;
        if (busa.out_float !== va[got].f || cyc !== 3 + got) begin
          errors++; $display("FAIL b2b_%0d: got %h at cycle %0d expected %h at cycle %0d",
                             got, busa.out_float, cyc, va[got].f, 3 + got);
        end
        got++;
      end
      if (busa.in_valid && busa.in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    busa.in_valid = 1'b0;
    checks++;
    if (got !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", got); end
  endtask

  task automatic test_stall();
    int sent = 0, got = 0, cyc = 0;
    logic [15:0] held = '0;
    bit holding = 0;
    while (got < 8 && cyc < 60) begin
      busa.out_ready = !(cyc >= 5 && cyc < 9);
      busa.in_valid  = (sent < 8);
      busa.in_fixed  = va[sent < 8 ? sent : 7].x;
      #1;
      checks++;
      if (busa.in_ready !== busa.out_ready) begin
        errors++; $display("FAIL stall_in_ready_c%0d: got %b expected %b", cyc, busa.in_ready, busa.out_ready);
      end
      if (busa.out_valid && !busa.out_ready) begin
        if (holding) begin
          checks++;
          if (busa.out_float !== held) begin
            errors++; $display("FAIL stall_hold_c%0d: got %h expected %h", cyc, busa.out_float, held);
          end
        end
        held = busa.out_float;
        holding = 1;
      end
      if (busa.out_valid && busa.out_ready) begin
        $display("txn stall idx=%0d out=%h cyc=%0d", got, busa.out_float, cyc);
        checks++;
        if (busa.out_float !== va[got].f) begin
          errors++; $display("FAIL stall_order_%0d: got %h expected %h", got, busa.out_float, va[got].f);
        end
        got++;
        holding = 0;
      end
      if (busa.in_valid && busa.in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    busa.in_valid  = 1'b0;
    busa.out_ready = 1'b1;
    checks++;
    if (got !== 8 || sent !== 8) begin
      errors++; $display("FAIL stall_count: got %0d out / %0d in expected 8 / 8", got, sent);
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (busa.out_valid !== 1'b0) begin errors++; $display("FAIL stall_dup: out_valid got %b expected 0", busa.out_valid); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] f; logic o, u; int lat;
    busa.out_ready = 1'b1;
    busa.in_valid = 1'b1; busa.in_fixed = 32'h0010_0000;
    @(posedge clk); #1;
    busa.in_fixed = 32'h8000_0000;
    @(posedge clk); #1;
    busa.in_valid = 1'b0;
    areset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busa.out_valid !== 1'b0 || busa.in_ready !== 1'b0) begin
      errors++; $display("FAIL midreset: out_valid=%b in_ready=%b expected 0 0", busa.out_valid, busa.in_ready);
    end
    areset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (busa.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_flush: out_valid got %b expected 0", busa.out_valid); end
    end
    run_one(1'b0, 32'hFFD8_0000, f, o, u, lat);
    checks++;
    if (f !== 16'hC100 || lat !== 3 || o !== 1'b0 || u !== 1'b0) begin
      errors++; $display("FAIL midreset_after: got %h lat=%0d %b %b expected c100 lat=3 0 0", f, lat, o, u);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_radix0();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
